// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the read-side and write-side FIFO controllers.
// Conversions work on a wide container so any pointer width up to PTR_MAX_W fits.
package fifo_pkg;

  localparam int PTR_MAX_W = 16;
  localparam int PTR_IDX_W = 4;

  typedef logic [PTR_MAX_W-1:0] ptr_t;
  typedef logic [PTR_IDX_W-1:0] bit_idx_t;

  // Pointer width for a FIFO of depth 2**addr_w: one extra wrap bit.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Picks one bit out of a converted pointer so callers can keep narrow nets.
  function automatic logic ptr_bit(input ptr_t v, input bit_idx_t i);
    return v[i];
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a Gray-coded bus entering this clock domain.
// Every stage clears to RST_VAL on reset.
module synchronizer #(
  parameter int                    SYNC_WIDTH = 1,
  parameter int                    SYNC_DLY   = 2,
  parameter logic [SYNC_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [SYNC_WIDTH-1:0] i_d,
  output logic [SYNC_WIDTH-1:0] o_q
);

  logic [SYNC_DLY-1:0][SYNC_WIDTH-1:0] r_stage;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stage <= {SYNC_DLY{RST_VAL}};
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_DLY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[SYNC_DLY-1];

endmodule

// File: rtl/fifo_rd_ctrl_p.sv
// Read-side controller of an asynchronous FIFO: synchronizes the write pointer,
// derives empty/level flags and issues memory read strobes.
module fifo_rd_ctrl_p
  import fifo_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int SYNC_DLY = 2,
  parameter int RD_LAT   = 1,
  parameter int AE_THR   = 1
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wr_ptr_g,
  input  logic              rd_req,
  input  logic              uf_clr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [ADDR_W:0]   rd_ptr_g,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam int          PW       = ptr_width(ADDR_W);
  localparam logic [31:0] AE_THR_U = 32'(AE_THR);

  logic [PW-1:0]     w_wr_sync;
  logic [PW-1:0]     w_wr_ptr_b;
  logic [PW-1:0]     w_rd_ptr_b_next;
  logic [PW-1:0]     w_rd_ptr_g_next;
  logic [PW-1:0]     w_level;
  logic              w_empty;
  logic              w_rd_en;
  logic [PW-1:0]     r_rd_ptr_b;
  logic [PW-1:0]     r_rd_ptr_g;
  logic [RD_LAT-1:0] r_valid_pipe;
  logic              r_underflow;

  synchronizer #(
    .SYNC_WIDTH (PW),
    .SYNC_DLY   (SYNC_DLY),
    .RST_VAL    ('0)
  ) u_wr_sync (
    .i_clk (rd_clk),
    .i_rst (rst),
    .i_d   (wr_ptr_g),
    .o_q   (w_wr_sync)
  );

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_ptr_bits
      assign w_wr_ptr_b[gi]      = ptr_bit(gray2bin(ptr_t'(w_wr_sync)), bit_idx_t'(gi));
      assign w_rd_ptr_g_next[gi] = ptr_bit(bin2gray(ptr_t'(w_rd_ptr_b_next)), bit_idx_t'(gi));
    end
  endgenerate

  // Full compare including the wrap bit: equal index with differing MSB is full.
  assign w_empty         = (w_wr_ptr_b == r_rd_ptr_b);
  assign w_level         = w_wr_ptr_b - r_rd_ptr_b;
  assign w_rd_en         = rd_req && !w_empty;
  assign w_rd_ptr_b_next = r_rd_ptr_b + {{(PW-1){1'b0}}, w_rd_en};

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      r_rd_ptr_b <= '0;
      r_rd_ptr_g <= '0;
    end else begin
      r_rd_ptr_b <= w_rd_ptr_b_next;
      r_rd_ptr_g <= w_rd_ptr_g_next;
    end
  end

  // A fresh underflow outranks a simultaneous clear.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (rd_req && w_empty) begin
      r_underflow <= 1'b1;
    end else if (uf_clr) begin
      r_underflow <= 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      r_valid_pipe <= '0;
    end else begin
      r_valid_pipe[0] <= w_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_valid_pipe[i] <= r_valid_pipe[i-1];
      end
    end
  end

  assign rd_en        = w_rd_en;
  assign rd_addr      = r_rd_ptr_b[ADDR_W-1:0];
  assign rd_valid     = r_valid_pipe[RD_LAT-1];
  assign rd_ptr_g     = r_rd_ptr_g;
  assign empty        = w_empty;
  assign almost_empty = (32'(w_level) <= AE_THR_U);
  assign rd_level     = w_level;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl_p.sv
// Directed and random checks of fifo_rd_ctrl_p against a count-based FIFO model.
module tb_fifo_rd_ctrl_p;

  localparam int ADDR_W   = 3;
  localparam int SYNC_DLY = 2;
  localparam int RD_LAT   = 1;
  localparam int AE_THR   = 1;

  logic       rd_clk;
  logic       rst;
  logic [3:0] wr_ptr_g;
  logic       rd_req;
  logic       uf_clr;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic       rd_valid;
  logic [3:0] rd_ptr_g;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_level;
  logic       underflow;

  fifo_rd_ctrl_p #(
    .ADDR_W   (ADDR_W),
    .SYNC_DLY (SYNC_DLY),
    .RD_LAT   (RD_LAT),
    .AE_THR   (AE_THR)
  ) dut (
    .rd_clk       (rd_clk),
    .rst          (rst),
    .wr_ptr_g     (wr_ptr_g),
    .rd_req       (rd_req),
    .uf_clr       (uf_clr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_ptr_g     (rd_ptr_g),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  int   n_vec  = 0;
  int   n_fail = 0;
  // Model: true write and read counts; the write count reaches the flags SYNC_DLY edges late.
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   hist[$];
  bit   vq[$];
  bit   m_uf   = 1'b0;
  bit   known  = 1'b0;
  bit   prev_ok = 1'b0;
  logic [3:0] prev_g = '0;
  bit   last_en = 1'b0;

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit i_rst, input bit i_req, input bit i_clr);
    int  seen;
    int  lvl;
    bit  e_empty;
    bit  e_en;
    if (i_rst) wr_cnt = 0;
    rst      = i_rst;
    rd_req   = i_req;
    uf_clr   = i_clr;
    wr_ptr_g = gray4(wr_cnt);
    #1;
    seen    = hist[hist.size() - SYNC_DLY];
    lvl     = seen - rd_cnt;
    e_empty = (lvl == 0);
    e_en    = i_req && !e_empty;
    last_en = e_en;
    if (known) begin
      chk("rd_en",     32'(rd_en),        32'(e_en));
      chk("rd_addr",   32'(rd_addr),      32'(rd_cnt % 8));
      chk("rd_valid",  32'(rd_valid),     32'(vq[0]));
      chk("rd_ptr_g",  32'(rd_ptr_g),     32'(gray4(rd_cnt)));
      chk("empty",     32'(empty),        32'(e_empty));
      chk("almost_em", 32'(almost_empty), 32'(lvl <= AE_THR));
      chk("rd_level",  32'(rd_level),     32'(lvl));
      chk("underflow", 32'(underflow),    32'(m_uf));
      if (prev_ok) chk("gray_step", 32'($countones(rd_ptr_g ^ prev_g) <= 1), 32'd1);
      prev_g  = rd_ptr_g;
      prev_ok = 1'b1;
    end
    @(posedge rd_clk);
    if (i_rst) begin
      rd_cnt = 0;
      m_uf   = 1'b0;
      vq.delete();
      for (int i = 0; i < RD_LAT; i++) vq.push_back(1'b0);
      hist.delete();
      for (int i = 0; i < SYNC_DLY; i++) hist.push_back(0);
      known   = 1'b1;
      prev_ok = 1'b0;
    end else begin
      if (e_en) rd_cnt++;
      if (i_req && e_empty) m_uf = 1'b1;
      else if (i_clr) m_uf = 1'b0;
      vq.push_back(e_en);
      void'(vq.pop_front());
      hist.push_back(wr_cnt);
    end
    @(negedge rd_clk);
  endtask

  task automatic advance_wr(input int n);
    for (int i = 0; i < n; i++) begin
      wr_cnt++;
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bit rq;
    bit clr;
    bit rr;
    logic [2:0] wrap_addr[4];
    wrap_addr[0] = 3'd6;
    wrap_addr[1] = 3'd7;
    wrap_addr[2] = 3'd0;
    wrap_addr[3] = 3'd1;
    for (int i = 0; i < RD_LAT; i++) vq.push_back(1'b0);
    for (int i = 0; i < SYNC_DLY; i++) hist.push_back(0);
    rst = 1'b1; rd_req = 1'b1; uf_clr = 1'b0; wr_ptr_g = '0;
    @(negedge rd_clk);

    // Reset held three cycles with a pending request.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    #1;
    chk("rst_rd_en",    32'(rd_en),     32'd0);
    chk("rst_empty",    32'(empty),     32'd1);
    chk("rst_uf",       32'(underflow), 32'd0);
    chk("rst_rd_ptr_g", 32'(rd_ptr_g),  32'd0);
    chk("rst_valid",    32'(rd_valid),  32'd0);

    // Write pointer jumps to 3; flags follow two edges later.
    wr_cnt = 3;
    step(1'b0, 1'b0, 1'b0);
    chk("lat_still_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("lat_empty", 32'(empty),    32'd0);
    chk("lat_level", 32'(rd_level), 32'd3);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty),     32'd1);
    chk("drain_uf",    32'(underflow), 32'd1);

    // Set beats clear, then clear alone.
    step(1'b0, 1'b1, 1'b1);
    chk("uf_set_wins", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("uf_cleared",  32'(underflow), 32'd0);

    // Full: eight ahead, index bits equal and wrap bit different.
    advance_wr(8);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    chk("full_empty", 32'(empty),        32'd0);
    chk("full_level", 32'(rd_level),     32'd8);
    chk("full_ae",    32'(almost_empty), 32'd0);

    // Bring the read pointer to 14, then straddle the wrap with write at 2 (18).
    repeat (8) step(1'b0, 1'b1, 1'b0);
    advance_wr(3);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    chk("wrap_rd_ptr_g", 32'(rd_ptr_g), 32'(gray4(14)));
    advance_wr(4);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    chk("wrap_level", 32'(rd_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", 32'(rd_addr), 32'(wrap_addr[i]));
      step(1'b0, 1'b1, 1'b0);
    end
    chk("wrap_end_g", 32'(rd_ptr_g), 32'(gray4(18)));

    // Reset in the cycle after a read strobe flushes the valid pulse.
    advance_wr(2);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("mid_valid_pre", 32'(rd_valid), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("mid_valid",   32'(rd_valid), 32'd0);
    chk("mid_rd_ptrg", 32'(rd_ptr_g), 32'd0);
    chk("mid_rd_addr", 32'(rd_addr),  32'd0);
    chk("mid_level",   32'(rd_level), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic with an occasional reset.
    for (int n = 0; n < 3000; n++) begin
      rq  = ($urandom % 4) != 0;
      clr = ($urandom % 16) == 0;
      rr  = ($urandom % 500) == 0;
      if (!rr && (wr_cnt - rd_cnt) < 8 && ($urandom % 3) != 0) wr_cnt++;
      step(rr, rq, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
